// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the flash array read sequencer.
// Register offsets, TIMING reset value, field positions and the FSM state encoding.
package flash_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SENSE1,
    SENSE2,
    OUT
  } state_t;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_TIMING = 8'h08;
  localparam logic [7:0] OFF_DATA0  = 8'h10;
  localparam logic [7:0] OFF_DATA1  = 8'h14;
  localparam logic [7:0] OFF_DATA2  = 8'h18;
  localparam logic [7:0] OFF_DATA3  = 8'h1C;

  localparam logic [31:0] TIMING_RST = 32'h0004_0804;

  localparam int CTRL_START  = 0;
  localparam int CTRL_WORD   = 1;
  localparam int CTRL_SCAN   = 3;
  localparam int CTRL_IRQ_EN = 4;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_OVR      = 2;

  function automatic logic [3:0] group_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/flash_read_sequencer_if.sv
// Wishbone slave port bundle between the wrapper bus and the sequencer register file.
interface flash_read_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/flash_seq_wb_regs.sv
// Wishbone decode, registered single-cycle ack and CTRL/STATUS/TIMING/DATA registers.
// Ack one cycle after a strobe in the window; write side effects land on the edge ending the ack.
module flash_seq_wb_regs
  import flash_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  flash_read_sequencer_if.slave wb,
  input  logic                 busy,
  input  logic                 seq_done,
  input  logic                 cap_vld,
  input  logic [1:0]           cap_idx,
  input  logic [7:0]           cap_dat,
  output logic                 start_p,
  output logic [1:0]           start_word,
  output logic                 start_scan,
  output logic [CNT_W-1:0]     t_sen1,
  output logic [CNT_W-1:0]     t_sen2,
  output logic [CNT_W-1:0]     t_out,
  output logic                 irq
);

  logic        ack_q, we_q;
  logic [7:0]  off_q;
  logic [23:0] wdat_q;
  logic [2:0]  sel_q;
  logic [1:0]  word_q;
  logic        scan_q, irq_en_q, done_q, ovr_q;
  logic [23:0] timing_q;
  logic [7:0]  data_q [4];
  logic [31:0] rdat;
  logic        hit, acc, wr, start_req, ovr_set;
  logic        unused_bits;

  assign unused_bits = ^{wb.wbs_dat_i[31:24], wb.wbs_sel_i[3]};

  assign hit = (wb.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign acc = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~ack_q;
  assign wr  = ack_q & we_q;

  // Start is judged against busy at the ack edge, so a start in the completion cycle is an overrun.
  assign start_req  = wr && (off_q == OFF_CTRL) && sel_q[0] && wdat_q[CTRL_START];
  assign start_p    = start_req & ~busy;
  assign ovr_set    = start_req & busy;
  assign start_word = wdat_q[CTRL_WORD +: 2];
  assign start_scan = wdat_q[CTRL_SCAN];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      off_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      word_q   <= '0;
      scan_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      timing_q <= TIMING_RST[23:0];
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      ack_q <= acc;
      if (acc) begin
        we_q   <= wb.wbs_we_i;
        off_q  <= wb.wbs_adr_i[7:0];
        wdat_q <= wb.wbs_dat_i[23:0];
        sel_q  <= wb.wbs_sel_i[2:0];
      end
      if (wr && off_q == OFF_CTRL && sel_q[0]) begin
        word_q   <= wdat_q[CTRL_WORD +: 2];
        scan_q   <= wdat_q[CTRL_SCAN];
        irq_en_q <= wdat_q[CTRL_IRQ_EN];
      end
      if (wr && off_q == OFF_TIMING) begin
        for (int b = 0; b < 3; b++)
          if (sel_q[b]) timing_q[8*b +: 8] <= wdat_q[8*b +: 8];
      end
      if (seq_done)
        done_q <= 1'b1;
      else if (start_p || (wr && off_q == OFF_STATUS && sel_q[0] && wdat_q[ST_DONE]))
        done_q <= 1'b0;
      if (ovr_set)
        ovr_q <= 1'b1;
      else if (wr && off_q == OFF_STATUS && sel_q[0] && wdat_q[ST_OVR])
        ovr_q <= 1'b0;
      if (cap_vld) data_q[cap_idx] <= cap_dat;
    end
  end

  always_comb begin
    rdat = '0;
    case (off_q)
      OFF_CTRL:   rdat = {27'b0, irq_en_q, scan_q, word_q, 1'b0};
      OFF_STATUS: rdat = {29'b0, ovr_q, done_q, busy};
      OFF_TIMING: rdat = {8'b0, timing_q};
      OFF_DATA0:  rdat = {24'b0, data_q[0]};
      OFF_DATA1:  rdat = {24'b0, data_q[1]};
      OFF_DATA2:  rdat = {24'b0, data_q[2]};
      OFF_DATA3:  rdat = {24'b0, data_q[3]};
      default:    rdat = '0;
    endcase
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = ack_q ? rdat : 32'b0;
  assign t_sen1       = timing_q[0 +: CNT_W];
  assign t_sen2       = timing_q[8 +: CNT_W];
  assign t_out        = timing_q[16 +: CNT_W];
  assign irq          = done_q & irq_en_q;

endmodule

// File: rtl/flash_read_sequencer.sv
// Sequences sen1 -> sen1+sen2 -> out_en[idx] phases and captures arr_out; single read done t1+t2+t3+1 cycles after start ack.
// Wishbone never stalls beyond the single registered ack; a start while busy only flags overrun.
module flash_read_sequencer
  import flash_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  flash_read_sequencer_if.slave wb,
  output logic                  sen1,
  output logic                  sen2,
  output logic [3:0]            out_en,
  input  logic [7:0]            arr_out,
  output logic                  irq
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d, word_q, word_d;
  logic              scan_q, scan_d;
  logic              sen1_q, sen2_q;
  logic [3:0]        out_en_q;
  logic              start_p, start_scan, seq_done, cap_vld, busy;
  logic [1:0]        start_word;
  logic [CNT_W-1:0]  t_sen1, t_sen2, t_out;

  // A programmed duration of 0 behaves as 1 cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  assign busy = (state_q != IDLE);

  flash_seq_wb_regs #(.ADDR_BASE(ADDR_BASE), .CNT_W(CNT_W)) u_regs (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wb         (wb),
    .busy       (busy),
    .seq_done   (seq_done),
    .cap_vld    (cap_vld),
    .cap_idx    (idx_q),
    .cap_dat    (arr_out),
    .start_p    (start_p),
    .start_word (start_word),
    .start_scan (start_scan),
    .t_sen1     (t_sen1),
    .t_sen2     (t_sen2),
    .t_out      (t_out),
    .irq        (irq)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    scan_d   = scan_q;
    cap_vld  = 1'b0;
    seq_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = SENSE1;
          cnt_d   = phase_load(t_sen1);
          word_d  = start_word;
          scan_d  = start_scan;
        end
      end
      SENSE1: begin
        if (cnt_q == '0) begin
          state_d = SENSE2;
          cnt_d   = phase_load(t_sen2);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      SENSE2: begin
        if (cnt_q == '0) begin
          state_d = OUT;
          idx_d   = scan_q ? 2'd0 : word_q;
          cnt_d   = phase_load(t_out);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      OUT: begin
        if (cnt_q == '0) begin
          cap_vld = 1'b1;
          if (scan_q && idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            cnt_d = phase_load(t_out);
          end else begin
            state_d  = IDLE;
            seq_done = 1'b1;
          end
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Array enables are flops fed from the next state so group changes never glitch.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      scan_q   <= 1'b0;
      sen1_q   <= 1'b0;
      sen2_q   <= 1'b0;
      out_en_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      scan_q   <= scan_d;
      sen1_q   <= (state_d != IDLE);
      sen2_q   <= (state_d == SENSE2) || (state_d == OUT);
      out_en_q <= (state_d == OUT) ? group_onehot(idx_d) : 4'b0;
    end
  end

  assign sen1   = sen1_q;
  assign sen2   = sen2_q;
  assign out_en = out_en_q;

endmodule
